if_fetch_unit: RTL and testbench

Instruction fetch stage. Sits directly downstream of the control unit. It owns the program counter and issues word fetches on a req/gnt/rvalid instruction bus. Returned instructions are buffered in a small queue toward the ID stage. When the control unit's registered jump_en/jump_addr fires, the PC is redirected and every stale fetch is discarded, both queued and in flight.

---
 rtl/if_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC and issues word fetches on a req/gnt/rvalid bus.
// Returned instructions are queued toward ID; a redirect flushes both queued and in-flight fetches.
module if_fetch_unit #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned            QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic                  ibus_req_o,
    output logic [ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                  ibus_gnt_i,
    input  logic                  ibus_rvalid_i,
    input  logic [31:0]           ibus_rdata_i,
    output logic                  inst_valid_o,
    output logic [31:0]           inst_o,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    input  logic                  inst_ready_i
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [CNT_W-1:0]      outstanding_q, outstanding_next;
    logic [CNT_W-1:0]      discard_q;

    logic [ADDR_WIDTH-1:0] tag_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      tag_wr_q, tag_rd_q;

    logic [31:0]           q_inst [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr [QUEUE_DEPTH];
    logic [PTR_W-1:0]      q_wr_q, q_rd_q;
    logic [CNT_W-1:0]      q_count_q;

    logic                  can_issue, fire, pop, push, drop;
    logic [OCC_W-1:0]      occupancy;
    logic [1:0]            unused_jump_low;

    assign unused_jump_low = jump_addr_i[1:0];

    assign inst_valid_o = (q_count_q != '0);
    assign inst_o       = q_inst[q_rd_q];
    assign inst_addr_o  = q_addr[q_rd_q];
    assign ibus_addr_o  = pc_q;

    // Credit counts the head leaving this cycle so a depth-2 queue sustains one fetch per cycle.
    assign pop       = inst_valid_o && inst_ready_i;
    assign occupancy = OCC_W'(q_count_q) + OCC_W'(outstanding_q) - OCC_W'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        can_issue  = 1'b0;
        ibus_req_o = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                can_issue  = (occupancy < OCC_W'(QUEUE_DEPTH));
                ibus_req_o = can_issue && !jump_en_i;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // A grant coinciding with a redirect is still a real bus transaction, so it is tracked.
    assign fire             = can_issue && ibus_gnt_i;
    assign drop             = (discard_q != '0) || jump_en_i;
    assign push             = ibus_rvalid_i && !drop;
    assign outstanding_next = outstanding_q + CNT_W'(fire) - CNT_W'(ibus_rvalid_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            outstanding_q <= outstanding_next;
            if (jump_en_i) begin
                pc_q <= {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
            end else if (fire) begin
                pc_q <= pc_q + ADDR_WIDTH'(4);
            end
            if (fire) begin
                tag_mem[tag_wr_q] <= pc_q;
                tag_wr_q          <= tag_wr_q + 1'b1;
            end
            if (ibus_rvalid_i) begin
                tag_rd_q <= tag_rd_q + 1'b1;
            end
            // Everything still in flight after this cycle belongs to the old stream.
            if (jump_en_i) begin
                discard_q <= outstanding_next;
            end else if (ibus_rvalid_i && (discard_q != '0)) begin
                discard_q <= discard_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr_q    <= '0;
            q_rd_q    <= '0;
            q_count_q <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_inst[i] <= NOP;
                q_addr[i] <= '0;
            end
        end else if (jump_en_i) begin
            q_wr_q    <= '0;
            q_rd_q    <= '0;
            q_count_q <= '0;
        end else begin
            if (push) begin
                q_inst[q_wr_q] <= ibus_rdata_i;
                q_addr[q_wr_q] <= tag_mem[tag_rd_q];
                q_wr_q         <= q_wr_q + 1'b1;
            end
            if (pop) begin
                q_rd_q <= q_rd_q + 1'b1;
            end
            q_count_q <= q_count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory model that returns each word's own address.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    int          checks = 0;
    int          passes = 0;
    bit          hold_resp = 0;
    logic [31:0] pend[$];

    if_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_ready_i (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The bus accepts on gnt, including a grant given in the same cycle as a redirect.
    task automatic cycle();
        @(negedge clk);
        if (ibus_gnt_i && (ibus_req_o || jump_en_i)) pend.push_back(ibus_addr_o);
        @(posedge clk);
        #1;
        if (!hold_resp && pend.size() > 0) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = pend.pop_front();
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = '0;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        jump_en_i    = 1'b0;
        jump_addr_i  = '0;
        ibus_gnt_i   = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i = '0;
        inst_ready_i = 1'b0;
        hold_resp    = 1'b0;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        jump_en_i    = 1'b0;
        jump_addr_i  = '0;
        ibus_gnt_i   = 1'b1;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i = '0;
        inst_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ibus_req_o !== 1'b0) $display("[TB] FAIL reset_req: got %0b want 0", ibus_req_o); else passes++;
        checks++; if (ibus_addr_o !== 32'h0) $display("[TB] FAIL reset_addr: got %h want 0", ibus_addr_o); else passes++;
        checks++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %0b want 0", inst_valid_o); else passes++;
        checks++; if (inst_o !== 32'h13) $display("[TB] FAIL reset_inst: got %h want 00000013", inst_o); else passes++;
        checks++; if (inst_addr_o !== 32'h0) $display("[TB] FAIL reset_inst_addr: got %h want 0", inst_addr_o); else passes++;
    endtask

    task automatic test_stream();
        do_reset();
        ibus_gnt_i   = 1'b1;
        inst_ready_i = 1'b1;
        #1;
        checks++; if (ibus_req_o !== 1'b0) $display("[TB] FAIL boot_req: got %0b want 0", ibus_req_o); else passes++;
        cycle();
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) $display("[TB] FAIL first_req: got req=%0b addr=%h want 1/0", ibus_req_o, ibus_addr_o); else passes++;
        cycle();
        checks++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL early_valid: got %0b want 0", inst_valid_o); else passes++;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(4 * i) || inst_o !== 32'(4 * i))
                $display("[TB] FAIL stream_%0d: got v=%0b addr=%h inst=%h want 1/%h/%h", i, inst_valid_o, inst_addr_o, inst_o, 4 * i, 4 * i);
            else passes++;
        end
    endtask

    task automatic test_hold();
        do_reset();
        ibus_gnt_i   = 1'b1;
        inst_ready_i = 1'b0;
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (ibus_req_o !== 1'b0) $display("[TB] FAIL hold_req_%0d: got %0b want 0", i, ibus_req_o); else passes++;
        end
        inst_ready_i = 1'b1;
        #1;
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) $display("[TB] FAIL hold_head: got v=%0b addr=%h want 1/0", inst_valid_o, inst_addr_o); else passes++;
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h8) $display("[TB] FAIL hold_resume_req: got req=%0b addr=%h want 1/8", ibus_req_o, ibus_addr_o); else passes++;
        cycle();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h4) $display("[TB] FAIL hold_order_4: got v=%0b addr=%h want 1/4", inst_valid_o, inst_addr_o); else passes++;
        cycle();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8 || inst_o !== 32'h8) $display("[TB] FAIL hold_order_8: got v=%0b addr=%h inst=%h want 1/8/8", inst_valid_o, inst_addr_o, inst_o); else passes++;
    endtask

    task automatic test_redirect();
        bit found;
        do_reset();
        ibus_gnt_i   = 1'b1;
        inst_ready_i = 1'b1;
        repeat (3) cycle();
        hold_resp = 1'b1;
        repeat (2) cycle();
        checks++; if (ibus_req_o !== 1'b0 || pend.size() != 2) $display("[TB] FAIL redir_setup: got req=%0b pending=%0d want 0/2", ibus_req_o, pend.size()); else passes++;
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h103;
        ibus_gnt_i  = 1'b0;
        cycle();
        jump_en_i  = 1'b0;
        ibus_gnt_i = 1'b1;
        #1;
        checks++; if (ibus_addr_o !== 32'h100) $display("[TB] FAIL redir_addr: got %h want 100", ibus_addr_o); else passes++;
        checks++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL redir_flush: got %0b want 0", inst_valid_o); else passes++;
        hold_resp = 1'b0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (inst_valid_o === 1'b1) found = 1;
        end
        checks++; if (!found || inst_addr_o !== 32'h100 || inst_o !== 32'h100) $display("[TB] FAIL redir_first: got found=%0b addr=%h inst=%h want 1/100/100", found, inst_addr_o, inst_o); else passes++;
    endtask

    task automatic test_stall();
        bit found;
        do_reset();
        ibus_gnt_i   = 1'b1;
        inst_ready_i = 1'b1;
        repeat (5) cycle();
        ibus_gnt_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h10) $display("[TB] FAIL stall_%0d: got req=%0b addr=%h want 1/10", i, ibus_req_o, ibus_addr_o); else passes++;
            if (i < 2) cycle();
        end
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h40;
        #1;
        checks++; if (ibus_req_o !== 1'b0) $display("[TB] FAIL stall_withdraw: got %0b want 0", ibus_req_o); else passes++;
        cycle();
        jump_en_i  = 1'b0;
        ibus_gnt_i = 1'b1;
        #1;
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h40) $display("[TB] FAIL stall_jump_req: got req=%0b addr=%h want 1/40", ibus_req_o, ibus_addr_o); else passes++;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (inst_valid_o === 1'b1) found = 1;
        end
        checks++; if (!found || inst_addr_o !== 32'h40) $display("[TB] FAIL stall_first: got found=%0b addr=%h want 1/40", found, inst_addr_o); else passes++;
    endtask

    task automatic test_coincident();
        bit found;
        do_reset();
        ibus_gnt_i   = 1'b1;
        inst_ready_i = 1'b1;
        repeat (2) cycle();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h200;
        cycle();
        jump_en_i = 1'b0;
        #1;
        checks++; if (inst_valid_o !== 1'b0) $display("[TB] FAIL coinc_empty: got %0b want 0", inst_valid_o); else passes++;
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h200) $display("[TB] FAIL coinc_req: got req=%0b addr=%h want 1/200", ibus_req_o, ibus_addr_o); else passes++;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            if (inst_valid_o === 1'b1) found = 1;
        end
        checks++; if (!found || inst_addr_o !== 32'h200) $display("[TB] FAIL coinc_first: got found=%0b addr=%h want 1/200", found, inst_addr_o); else passes++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        ibus_gnt_i   = 1'b1;
        inst_ready_i = 1'b0;
        repeat (4) cycle();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) $display("[TB] FAIL mid_queued: got v=%0b addr=%h want 1/0", inst_valid_o, inst_addr_o); else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0) $display("[TB] FAIL mid_req: got req=%0b addr=%h want 0/0", ibus_req_o, ibus_addr_o); else passes++;
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || inst_addr_o !== 32'h0) $display("[TB] FAIL mid_outputs: got v=%0b inst=%h addr=%h want 0/00000013/0", inst_valid_o, inst_o, inst_addr_o); else passes++;
        pend.delete();
        ibus_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        inst_ready_i = 1'b1;
        cycle();
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) $display("[TB] FAIL mid_restart: got req=%0b addr=%h want 1/0", ibus_req_o, ibus_addr_o); else passes++;
        repeat (2) cycle();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) $display("[TB] FAIL mid_first: got v=%0b addr=%h want 1/0", inst_valid_o, inst_addr_o); else passes++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_stall();
        test_coincident();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
